// File: rtl/sparse_fedp_acc.sv
// sparse_fedp_acc -- 2:4 structured-sparse fused dot-product with chunk
// accumulation.
//
// Each beat carries GROUPS groups of four dense activations and two
// compressed nonzero weights per group, each weight with a 2-bit position
// index. Stage 1 selects the indexed activation for each weight slot and
// registers the 2*GROUPS products. Stage 2 reduces the products in an adder
// tree and accumulates them over a multi-beat K-chunk that is delimited by
// first/last markers and seeded with an external partial sum.
//
// Optional feature: define SPARSE_FEDP_SAT_EN to clamp every accumulator
// update to the signed ACC_W range. When it is undefined, the accumulator
// wraps modulo 2^ACC_W.
//
// Parameters:
//   DW     signed activation/weight width
//   GROUPS number of 4-element groups per beat
//   ACC_W  signed accumulator/result width (>= 2*DW + clog2(2*GROUPS) + 1)
//
// Ports:
//   clk          rising-edge clock
//   rstn         asynchronous active-low reset
//   in_valid     beat valid
//   in_first     first beat of a chunk (qualified by in_valid)
//   in_last      last beat of a chunk (qualified by in_valid)
//   in_act       activations, group g element e at [(g*4+e)*DW +: DW]
//   in_wgt       nonzero weights, group g slot s at [(g*2+s)*DW +: DW]
//   in_idx       positions, group g slot s at [(g*2+s)*2 +: 2]
//   partial_sum  chunk seed, sampled on a valid first beat
//   out_valid    one-cycle pulse marking a completed chunk
//   result       completed chunk sum, held between pulses
//   err          sticky protocol error, cleared only by reset

module sparse_fedp_acc #(
  parameter int DW     = 8,
  parameter int GROUPS = 2,
  parameter int ACC_W  = 32
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_valid,
  input  logic                   in_first,
  input  logic                   in_last,
  input  logic [GROUPS*4*DW-1:0] in_act,
  input  logic [GROUPS*2*DW-1:0] in_wgt,
  input  logic [GROUPS*4-1:0]    in_idx,
  input  logic [ACC_W-1:0]       partial_sum,
  output logic                   out_valid,
  output logic [ACC_W-1:0]       result,
  output logic                   err
);

  localparam int NP = 2 * GROUPS;
  localparam int PW = 2 * DW;

  // The wrap build only needs the low ACC_W bits of every sum, so the
  // guard bits are kept only where the clamp has to see the true value.
`ifdef SPARSE_FEDP_SAT_EN
  localparam int TW = ACC_W + 2;
`else
  localparam int TW = ACC_W;
`endif

  typedef logic signed [TW-1:0] sum_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  // ---------------------------------------------------------------------
  // Stage 1: activation select and multiply
  // ---------------------------------------------------------------------
  logic signed [PW-1:0] prod_d [NP];
  logic signed [PW-1:0] prod_q [NP];
  logic                 v1_q;
  logic                 f1_q;
  logic                 l1_q;
  logic [ACC_W-1:0]     psum1_q;

  always_comb begin
    logic [1:0]           sel;
    logic signed [DW-1:0] a_s;
    logic signed [DW-1:0] w_s;
    sel = '0;
    a_s = '0;
    w_s = '0;
    for (int unsigned g = 0; g < GROUPS; g++) begin
      for (int unsigned s = 0; s < 2; s++) begin
        sel = in_idx[(g*2+s)*2 +: 2];
        a_s = $signed(in_act[(g*4+sel)*DW +: DW]);
        w_s = $signed(in_wgt[(g*2+s)*DW +: DW]);
        prod_d[g*2+s] = PW'(a_s) * PW'(w_s);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1_q    <= 1'b0;
      f1_q    <= 1'b0;
      l1_q    <= 1'b0;
      psum1_q <= '0;
      for (int unsigned i = 0; i < NP; i++) begin
        prod_q[i] <= '0;
      end
    end else begin
      v1_q <= in_valid;
      // Payload only moves on valid beats; stage 2 ignores it otherwise.
      if (in_valid) begin
        f1_q    <= in_first;
        l1_q    <= in_last;
        psum1_q <= partial_sum;
        prod_q  <= prod_d;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: adder tree, accumulator, protocol tracking
  // ---------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] result_q, result_d;
  logic             out_valid_q, out_valid_d;
  logic             err_q, err_d;

  sum_t             tree_sum;
  sum_t             sum_full;
  logic [ACC_W-1:0] acc_new;
  logic             take;

`ifdef SPARSE_FEDP_SAT_EN
  localparam sum_t SAT_MAX = sum_t'({1'b0, {(ACC_W-1){1'b1}}});
  localparam sum_t SAT_MIN = ~SAT_MAX;
`endif

  always_comb begin
    tree_sum = '0;
    for (int unsigned i = 0; i < NP; i++) begin
      tree_sum = tree_sum + sum_t'(prod_q[i]);
    end
  end

  // A first beat seeds from partial_sum; any other beat adds onto acc.
  always_comb begin
    sum_full = (f1_q ? sum_t'($signed(psum1_q)) : sum_t'($signed(acc_q)))
             + tree_sum;
`ifdef SPARSE_FEDP_SAT_EN
    if (sum_full > SAT_MAX) begin
      acc_new = {1'b0, {(ACC_W-1){1'b1}}};
    end else if (sum_full < SAT_MIN) begin
      acc_new = {1'b1, {(ACC_W-1){1'b0}}};
    end else begin
      acc_new = sum_full[ACC_W-1:0];
    end
`else
    acc_new = sum_full;
`endif
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    result_d    = result_q;
    out_valid_d = 1'b0;
    err_d       = err_q;
    take        = 1'b0;

    if (v1_q) begin
      if (f1_q) begin
        // A first inside an open chunk abandons that chunk and restarts.
        if (state_q == ST_ACTIVE) begin
          err_d = 1'b1;
        end
        take = 1'b1;
      end else if (state_q == ST_ACTIVE) begin
        take = 1'b1;
      end else begin
        // Continuation with no open chunk: dropped entirely, even if last.
        err_d = 1'b1;
      end
    end

    if (take) begin
      acc_d   = acc_new;
      state_d = ST_ACTIVE;
      if (l1_q) begin
        result_d    = acc_new;
        out_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign err       = err_q;

endmodule

// File: tb/tb_sparse_fedp_acc.sv
// Self-checking bench for sparse_fedp_acc. Two instances (ACC_W = 32 and
// ACC_W = 18) share one stimulus stream; a chunk-level reference model
// predicts out_valid, result and err for both, one beat at a time.

module tb_sparse_fedp_acc;

  localparam int DW = 8;
  localparam int G  = 2;

  logic               clk = 1'b0;
  logic               rstn;
  logic               in_valid, in_first, in_last;
  logic [G*4*DW-1:0]  act_v;
  logic [G*2*DW-1:0]  wgt_v;
  logic [G*4-1:0]     idx_v;
  logic [31:0]        psum32_v;
  logic [17:0]        psum18_v;
  logic               ov32, err32, ov18, err18;
  logic [31:0]        res32;
  logic [17:0]        res18;

  always #5 clk = ~clk;

  sparse_fedp_acc #(.DW(DW), .GROUPS(G), .ACC_W(32)) u_dut32 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .in_act(act_v), .in_wgt(wgt_v), .in_idx(idx_v),
    .partial_sum(psum32_v), .out_valid(ov32), .result(res32), .err(err32)
  );

  sparse_fedp_acc #(.DW(DW), .GROUPS(G), .ACC_W(18)) u_dut18 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .in_act(act_v), .in_wgt(wgt_v), .in_idx(idx_v),
    .partial_sum(psum18_v), .out_valid(ov18), .result(res18), .err(err18)
  );

  int act [G][4];
  int wgt [G][2];
  int idx [G][2];

  typedef struct {
    bit     ov;
    longint r32;
    longint r18;
    bit     err;
  } exp_t;

  exp_t   exp_q[$];
  bit     m_active, m_err;
  longint m_acc32, m_acc18, m_res32, m_res18;
  int     n_tests = 0;
  int     n_fail  = 0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reduce an exact integer to what a w-bit signed accumulator holds.
  function automatic longint fit(input longint v, input int w);
    longint lim, m, r;
    lim = longint'(1) << (w - 1);
    m   = longint'(1) << w;
`ifdef SPARSE_FEDP_SAT_EN
    if (v > lim - 1) return lim - 1;
    if (v < -lim)    return -lim;
    return v;
`else
    r = v & (m - 1);
    if (r >= lim) r = r - m;
    return r;
`endif
  endfunction

  function automatic exp_t reset_entry();
    exp_t e;
    e.ov = 1'b0; e.r32 = 0; e.r18 = 0; e.err = 1'b0;
    return e;
  endfunction

  task automatic clear_arrays();
    for (int g = 0; g < G; g++) begin
      for (int e = 0; e < 4; e++) act[g][e] = 0;
      for (int s = 0; s < 2; s++) begin
        wgt[g][s] = 0;
        idx[g][s] = 0;
      end
    end
  endtask

  // Present one beat, advance the model, then compare the outputs that the
  // previous beat should now be showing.
  task automatic drive(input bit v, input bit f, input bit l,
                       input longint p32, input longint p18);
    exp_t   e, got_e;
    longint tree;
    bit     accepted;
    for (int g = 0; g < G; g++) begin
      for (int k = 0; k < 4; k++) act_v[(g*4+k)*DW +: DW] = act[g][k][DW-1:0];
      for (int s = 0; s < 2; s++) begin
        wgt_v[(g*2+s)*DW +: DW] = wgt[g][s][DW-1:0];
        idx_v[(g*2+s)*2 +: 2]   = idx[g][s][1:0];
      end
    end
    in_valid = v; in_first = f; in_last = l;
    psum32_v = p32[31:0];
    psum18_v = p18[17:0];

    e.ov = 1'b0;
    if (v) begin
      tree = 0;
      for (int g = 0; g < G; g++)
        for (int s = 0; s < 2; s++)
          tree += longint'(wgt[g][s]) * longint'(act[g][idx[g][s]]);
      accepted = 1'b0;
      if (f) begin
        if (m_active) m_err = 1'b1;
        m_acc32  = fit(p32 + tree, 32);
        m_acc18  = fit(p18 + tree, 18);
        m_active = 1'b1;
        accepted = 1'b1;
      end else if (m_active) begin
        m_acc32  = fit(m_acc32 + tree, 32);
        m_acc18  = fit(m_acc18 + tree, 18);
        accepted = 1'b1;
      end else begin
        m_err = 1'b1;
      end
      if (accepted && l) begin
        e.ov     = 1'b1;
        m_res32  = m_acc32;
        m_res18  = m_acc18;
        m_active = 1'b0;
      end
    end
    e.r32 = m_res32;
    e.r18 = m_res18;
    e.err = m_err;
    exp_q.push_back(e);

    @(posedge clk);
    #1;
    got_e = exp_q.pop_front();
    check_eq("ov32",  longint'(ov32),            longint'(got_e.ov));
    check_eq("res32", longint'($signed(res32)),  got_e.r32);
    check_eq("err32", longint'(err32),           longint'(got_e.err));
    check_eq("ov18",  longint'(ov18),            longint'(got_e.ov));
    check_eq("res18", longint'($signed(res18)),  got_e.r18);
    check_eq("err18", longint'(err18),           longint'(got_e.err));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic reset_dut();
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    rstn = 1'b0;
    #1;
    check_eq("rst_ov32",  longint'(ov32),  0);
    check_eq("rst_res32", longint'(res32), 0);
    check_eq("rst_err32", longint'(err32), 0);
    check_eq("rst_ov18",  longint'(ov18),  0);
    check_eq("rst_res18", longint'(res18), 0);
    check_eq("rst_err18", longint'(err18), 0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    m_active = 1'b0; m_err = 1'b0;
    m_acc32 = 0; m_acc18 = 0; m_res32 = 0; m_res18 = 0;
    exp_q.delete();
    exp_q.push_back(reset_entry());
  endtask

  initial begin
    bit     rv, rf, rl;
    logic [17:0] r18;
    rstn = 1'b1;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    act_v = '0; wgt_v = '0; idx_v = '0; psum32_v = '0; psum18_v = '0;
    clear_arrays();
    #2;
    reset_dut();

    // Single-beat chunk, including a repeated index in group 1.
    act[0] = '{1, 2, 3, 4};     idx[0] = '{0, 3}; wgt[0] = '{5, -2};
    act[1] = '{10, 20, 30, 40}; idx[1] = '{2, 2}; wgt[1] = '{1, 1};
    drive(1, 1, 1, 100, 100);
    idle(2);
    check_eq("single_beat", longint'($signed(res32)), 157);

    // Three beats of the most negative product sum with a bubble.
    for (int g = 0; g < G; g++) begin
      act[g] = '{-128, -128, -128, -128};
      wgt[g] = '{127, 127};
      idx[g] = '{1, 2};
    end
    drive(1, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    idle(1);
    drive(1, 0, 1, 0, 0);
    idle(2);
    check_eq("three_beat", longint'($signed(res32)), -195072);

    // Back-to-back single-beat chunks.
    clear_arrays();
    act[0][0] = 7; wgt[0][0] = 1;
    drive(1, 1, 1, 0, 0);
    act[0][0] = 9;
    drive(1, 1, 1, 0, 0);
    idle(2);
    check_eq("b2b_second", longint'($signed(res32)), 9);

    // Overflow of the 18-bit instance.
    clear_arrays();
    act[0][0] = 127; wgt[0][0] = 127;
    drive(1, 1, 1, 131071, 131071);
    idle(2);
`ifdef SPARSE_FEDP_SAT_EN
    check_eq("ovf18", longint'($signed(res18)), 131071);
`else
    check_eq("ovf18", longint'($signed(res18)), 131071 + 16129 - 262144);
`endif
    check_eq("ovf32", longint'($signed(res32)), 147200);
    check_eq("no_err_legal", longint'(err32), 0);

    // Continuation beat with no open chunk.
    reset_dut();
    clear_arrays();
    act[0][0] = 7; wgt[0][0] = 1;
    drive(1, 0, 1, 0, 0);
    idle(2);
    check_eq("err_orphan", longint'(err32), 1);

    // First inside an open chunk restarts it.
    reset_dut();
    clear_arrays();
    act[0][0] = 2; wgt[0][0] = 1;
    drive(1, 1, 0, 100, 100);
    act[0][0] = 1;
    drive(1, 1, 0, 5, 5);
    clear_arrays();
    drive(1, 0, 1, 0, 0);
    idle(2);
    check_eq("restart_res", longint'($signed(res32)), 6);
    check_eq("restart_err", longint'(err32), 1);

    // Reset in the middle of a chunk, then a fresh chunk.
    reset_dut();
    clear_arrays();
    act[0][0] = 4; wgt[0][0] = 3;
    drive(1, 1, 0, 50, 50);
    drive(1, 0, 0, 0, 0);
    reset_dut();
    clear_arrays();
    act[1][3] = 3; wgt[1][1] = 1; idx[1][1] = 3;
    drive(1, 1, 1, 0, 0);
    idle(2);
    check_eq("post_reset_res", longint'($signed(res32)), 3);
    check_eq("post_reset_err", longint'(err32), 0);

    // Random traffic, mostly protocol-clean.
    reset_dut();
    for (int n = 0; n < 800; n++) begin
      for (int g = 0; g < G; g++) begin
        for (int e = 0; e < 4; e++) act[g][e] = int'($urandom_range(0, 255)) - 128;
        for (int s = 0; s < 2; s++) begin
          wgt[g][s] = int'($urandom_range(0, 255)) - 128;
          idx[g][s] = int'($urandom_range(0, 3));
        end
      end
      rv = ($urandom_range(0, 3) != 0);
      if (m_active) rf = ($urandom_range(0, 15) == 0);
      else          rf = ($urandom_range(0, 15) != 0);
      rl = ($urandom_range(0, 2) == 0);
      r18 = 18'($urandom);
      drive(rv, rf, rl, longint'($signed($urandom)), longint'($signed(r18)));
      if (n == 400) reset_dut();
    end
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
